alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 34 +++
 rtl/alu_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, datapath width
// and the two-state output register encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_BAD = 3'b111;

    typedef logic state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both requesters; the unsupported op code
// produces a zero result and is flagged by the caller.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] result_o
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    assign a_s = a_i;
    assign b_s = b_i;

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_SLL:  result_o = a_i << b_i[4:0];
            OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_XOR:  result_o = a_i ^ b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_AND:  result_o = a_i & b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU with a one-deep
// registered response that drains and refills on the same edge.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              can_accept;
    logic              winner;
    logic              grant;
    logic [DATA_W-1:0] mux_a, mux_b;
    logic [2:0]        mux_op;
    logic [DATA_W-1:0] alu_res;

    // Readies are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || rsp_ready;
        winner     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        grant      = rst_n && can_accept && (req0_valid || req1_valid);
        req0_ready = grant && !winner;
        req1_ready = grant && winner;
        mux_a      = winner ? req1_a  : req0_a;
        mux_b      = winner ? req1_b  : req0_b;
        mux_op     = winner ? req1_op : req0_op;
    end

    alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (mux_a),
        .b_i      (mux_b),
        .op_i     (mux_op),
        .result_o (alu_res)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        if (grant) begin
            state_d  = ST_FULL;
            ptr_d    = ~winner;
            id_d     = winner;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            err_d    = (mux_op == OP_BAD);
        end else if (rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule
